data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the array; power of two, 2..4096.
REQ-002 Parameter LATENCY, default 2, clock edges from request acceptance to the ready pulse; range 1..15.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port req, input, 1, initiator request valid; held high with addr/we/wdata stable until ready.
REQ-006 Port we, input, 1, 1 = write, 0 = read.
REQ-007 Port addr, input, 32, byte address; word index = addr[31:2].
REQ-008 Port wdata, input, 32, write data.
REQ-009 Port rdata, output, 32, read data; valid only while ready=1.
REQ-010 Port ready, output, 1, one-cycle completion pulse.
REQ-011 Port err, output, 1, error flag; meaningful only while ready=1.
REQ-012 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP, with all outputs registered.
REQ-014 IDLE with req=1 at an edge SHALL accept: capture we/addr/wdata, load the counter with LATENCY-1, and go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-015 WAIT SHALL decrement the counter each edge and move to RESP on the edge where the counter is 1.
REQ-016 ready SHALL be 1 for exactly the one cycle spent in RESP, which begins LATENCY edges after the accept edge.
REQ-017 A write SHALL commit to the array on the edge that enters RESP; a read SHALL load rdata on that same edge.
REQ-018 Outside RESP, rdata SHALL be 0 and err SHALL be 0.
REQ-019 RESP SHALL return to IDLE unconditionally and ignore req, so there is at least one IDLE cycle between transactions; maximum throughput is one per LATENCY+1 cycles.
REQ-020 Captured values SHALL be used throughout a transaction; req dropping or addr changing after accept SHALL NOT alter the result.
REQ-021 If captured addr[31:2] >= DEPTH (out of range), the transaction SHALL complete with err=1 and rdata=0, and no write SHALL occur.
REQ-022 A read of a word never written SHALL return the array's uninitialised content; the bench SHALL NOT check this case.
REQ-023 Address wrap-around SHALL NOT occur, because out-of-range accesses are handled by REQ-021.

Reset
REQ-024 reset=1 at an edge SHALL force state IDLE, counter=0, ready=0, err=0, rdata=0 and busy=0.
REQ-025 reset SHALL have priority over every other event, including a simultaneous req or a pending RESP entry.
REQ-026 Reset in the middle of a transaction SHALL abort it, and a pending write SHALL NOT commit.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_ERR_EN SHALL control misalignment checking.
REQ-029 With DMEM_MISALIGN_ERR_EN defined, captured addr[1:0] != 0 SHALL complete with err=1 and rdata=0, with no write and the normal LATENCY timing.
REQ-030 Without DMEM_MISALIGN_ERR_EN, addr[1:0] SHALL be ignored and the access SHALL proceed on word addr[31:2].

Verification
REQ-031 Reset, then write addr=0x10 wdata=0xDEADBEEF with LATENCY=2: ready high exactly 2 edges after accept, err=0, busy high for 2 cycles.
REQ-032 Read addr=0x10 after REQ-031: rdata=0xDEADBEEF during the ready cycle, and rdata=0 the cycle after.
REQ-033 req held high continuously for four reads: accepts spaced LATENCY+1=3 cycles apart, with no double-accept in RESP.
REQ-034 Write to addr=0x100 with DEPTH=64: err=1, rdata=0; a subsequent read of word 0 is unchanged.
REQ-035 Write to addr=0x20, assert reset one cycle after accept: no ready pulse, busy=0, and a later read of 0x20 returns the old value.
REQ-036 Read addr=0x13: with DMEM_MISALIGN_ERR_EN, err=1 and rdata=0; without it, returns the word at 0x10.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between an initiator and the data memory responder
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory responder; DMEM_MISALIGN_ERR_EN turns addr[1:0] != 0 into an error
module data_mem_responder #(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic c_we, c_mis;
  logic [29:0] c_waddr;
  logic [31:0] c_wdata;
  logic [31:0] mem [DEPTH];
  logic l_mis, t_we, t_mis, bad, go_resp;
  logic [29:0] t_waddr;
  logic [31:0] t_wdata;
  logic [AW-1:0] idx;
`ifdef DMEM_MISALIGN_ERR_EN
  assign l_mis = |bus.addr[1:0];
`else
  assign l_mis = 1'b0;
`endif
  // in IDLE the live bus is used so that LATENCY=1 can complete on the accept edge
  always_comb begin
    t_we = state == IDLE ? bus.we : c_we;
    t_mis = state == IDLE ? l_mis : c_mis;
    t_waddr = state == IDLE ? bus.addr[31:2] : c_waddr;
    t_wdata = state == IDLE ? bus.wdata : c_wdata;
    idx = t_waddr[AW-1:0];
    bad = t_waddr >= 30'(DEPTH) || t_mis;
    go_resp = (state == IDLE && bus.req && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.ready <= 1'b0;
      bus.err <= 1'b0;
      bus.rdata <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.ready <= go_resp;
      bus.err <= go_resp && bad;
      bus.rdata <= go_resp && !t_we && !bad ? mem[idx] : '0;
      case (state)
        IDLE: if (bus.req) begin
          c_we <= bus.we;
          c_mis <= l_mis;
          c_waddr <= bus.addr[31:2];
          c_wdata <= bus.wdata;
          cnt <= 4'(LATENCY - 1);
          state <= LATENCY == 1 ? RESP : WAIT;
          bus.busy <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!reset && go_resp && t_we && !bad) mem[idx] <= t_wdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench for data_mem_responder against a word-array reference model
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT = 2;
  typedef struct {
    int acc;
    int rdy;
    bit err;
    logic [31:0] rdata;
    bit chk;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int next_ok = 0;
  exp_t q[$];
  logic [31:0] mdl [int];
  data_mem_responder_if bus();
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // monitor: every cycle, compare outputs against the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    check("busy", 32'(bus.busy), 32'(q.size() > 0 && cyc >= q[0].acc && cyc <= q[0].rdy));
    if (bus.ready) begin
      if (q.size() == 0) check("unexpected_ready", 32'(bus.ready), 32'd0);
      else begin
        e = q.pop_front();
        check("ready_cycle", 32'(cyc), 32'(e.rdy));
        check("err", 32'(bus.err), 32'(e.err));
        if (e.chk) check("rdata", bus.rdata, e.rdata);
      end
    end else begin
      check("idle_rdata", bus.rdata, 32'd0);
      check("idle_err", 32'(bus.err), 32'd0);
      if (q.size() > 0 && cyc >= q[0].rdy) begin
        check("missing_ready", 32'(bus.ready), 32'd1);
        void'(q.pop_front());
      end
    end
  end
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input bit scr);
    exp_t e;
    int wi;
    bit bad;
    bit mis;
    bus.req = 1'b1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    wi = int'(a[31:2]);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    mis = a[1:0] != 2'd0;
`endif
    bad = wi >= DEPTH || mis;
    e.acc = cyc + 1 > next_ok ? cyc + 1 : next_ok;
    e.rdy = e.acc + LAT - 1;
    e.err = bad;
    e.rdata = (!w && !bad && mdl.exists(wi)) ? mdl[wi] : 32'd0;
    e.chk = bad || (!w && mdl.exists(wi));
    q.push_back(e);
    next_ok = e.rdy + 2;
    while (cyc < e.rdy) begin
      @(negedge clk);
      if (scr && cyc == e.acc && cyc < e.rdy) begin
        bus.addr = $urandom;
        bus.wdata = $urandom;
        bus.we = 1'($urandom);
        bus.req = 1'($urandom);
      end
    end
    if (w && !bad) mdl[wi] = d;
  endtask
  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    e.acc = cyc + 1 > next_ok ? cyc + 1 : next_ok;
    e.rdy = e.acc + LAT - 1;
    e.err = 1'b0;
    e.rdata = 32'd0;
    e.chk = 1'b0;
    q.push_back(e);
    while (cyc < e.acc) @(negedge clk);
    #1;
    reset = 1'b1;
    bus.req = 1'b0;
    q.delete();
    @(negedge clk);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    next_ok = 0;
  endtask
  initial begin
    int wi;
    logic [31:0] a;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    idle(2);
    issue(1'b0, 32'h10, 32'd0, 1'b0);
    idle(2);
    issue(1'b1, 32'h0, 32'h12345678, 1'b0);
    idle(1);
    issue(1'b1, 32'h100, 32'hFFFFFFFF, 1'b0);
    idle(1);
    issue(1'b0, 32'h0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) issue(1'b0, i % 2 == 1 ? 32'h0 : 32'h10, 32'd0, 1'b0);
    idle(2);
    issue(1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
    idle(1);
    abort_write(32'h20, 32'h5A5A5A5A);
    idle(2);
    issue(1'b0, 32'h20, 32'd0, 1'b0);
    idle(1);
    issue(1'b0, 32'h13, 32'd0, 1'b0);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      wi = $urandom_range(0, DEPTH - 1);
      a = 32'(wi * 4) | 32'($urandom % 4);
      if ($urandom % 8 == 0) a = $urandom % 2 == 0 ? $urandom : 32'(DEPTH * 4) + 32'($urandom % 64);
      if ($urandom % 25 == 0) abort_write(a, $urandom);
      else issue(1'($urandom), a, $urandom, $urandom % 3 == 0);
      if ($urandom % 2 == 1) idle($urandom_range(1, 3));
    end
    idle(LAT + 4);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
